// File: rtl/falafel_mem_responder.sv
// Single-outstanding memory responder with a local word store, fixed response latency,
// and a compare-and-swap on an empty key (lock word lives at index 0).
module falafel_mem_responder #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 64,
    parameter int unsigned       RSP_LATENCY = 2,
    parameter logic [DATA_W-1:0] EMPTY_KEY   = '1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_req_val_i,
    output logic              mem_req_rdy_o,
    input  logic              mem_req_is_write_i,
    input  logic              mem_req_is_cas_i,
    input  logic [DATA_W-1:0] mem_req_addr_i,
    input  logic [DATA_W-1:0] mem_req_data_i,
    output logic              mem_rsp_val_o,
    input  logic              mem_rsp_rdy_i,
    output logic [DATA_W-1:0] mem_rsp_data_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned OFF_W = $clog2(DATA_W / 8);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_EXEC,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_write_q, is_write_d;
    logic               is_cas_q, is_cas_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               req_rdy_q, req_rdy_d;
    logic               rsp_val_q, rsp_val_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               mem_we;
    logic [DATA_W-1:0]  cur_word;

    // Byte-offset and above-store address bits are intentionally dropped (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem_req_addr_i[DATA_W-1:IDX_W+OFF_W], mem_req_addr_i[OFF_W-1:0]};

    assign cur_word = mem_q[idx_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_write_d = is_write_q;
        is_cas_d   = is_cas_q;
        idx_d      = idx_q;
        data_d     = data_q;
        req_rdy_d  = req_rdy_q;
        rsp_val_d  = rsp_val_q;
        rsp_data_d = rsp_data_q;
        mem_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (mem_req_val_i && req_rdy_q) begin
                    is_write_d = mem_req_is_write_i;
                    is_cas_d   = mem_req_is_cas_i;
                    idx_d      = mem_req_addr_i[IDX_W+OFF_W-1:OFF_W];
                    data_d     = mem_req_data_i;
                    cnt_d      = CNT_W'(RSP_LATENCY - 1);
                    req_rdy_d  = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_EXEC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_EXEC: begin
                state_d   = S_RESP;
                rsp_val_d = 1'b1;
                if (is_cas_q) begin
                    if (cur_word == EMPTY_KEY) begin
                        mem_we     = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        rsp_data_d = DATA_W'(1);
                    end
                end else if (is_write_q) begin
                    mem_we     = 1'b1;
                    rsp_data_d = '0;
                end else begin
                    rsp_data_d = cur_word;
                end
            end
            S_RESP: begin
                if (mem_rsp_rdy_i) begin
                    state_d    = S_IDLE;
                    rsp_val_d  = 1'b0;
                    rsp_data_d = '0;
                    req_rdy_d  = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                req_rdy_d  = 1'b1;
                rsp_val_d  = 1'b0;
                rsp_data_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            is_write_q <= 1'b0;
            is_cas_q   <= 1'b0;
            idx_q      <= '0;
            data_q     <= '0;
            req_rdy_q  <= 1'b1;
            rsp_val_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_write_q <= is_write_d;
            is_cas_q   <= is_cas_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            req_rdy_q  <= req_rdy_d;
            rsp_val_q  <= rsp_val_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    // Word 0 is the lock word and comes out of reset unlocked.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? EMPTY_KEY : '0;
            end
        end else if (mem_we) begin
            mem_q[idx_q] <= data_q;
        end
    end

    assign mem_req_rdy_o  = req_rdy_q;
    assign mem_rsp_val_o  = rsp_val_q;
    assign mem_rsp_data_o = rsp_data_q;

endmodule

// File: tb/tb_falafel_mem_responder.sv
// Directed bench for falafel_mem_responder: reads, writes, CAS, backpressure, wrap, reset abort.
module tb_falafel_mem_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_req_val_i;
    logic        mem_req_rdy_o;
    logic        mem_req_is_write_i;
    logic        mem_req_is_cas_i;
    logic [31:0] mem_req_addr_i;
    logic [31:0] mem_req_data_i;
    logic        mem_rsp_val_o;
    logic        mem_rsp_rdy_i;
    logic [31:0] mem_rsp_data_o;

    int compared   = 0;
    int mismatched = 0;

    falafel_mem_responder #(
        .DATA_W(32),
        .DEPTH(64),
        .RSP_LATENCY(2),
        .EMPTY_KEY(32'hFFFF_FFFF)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .mem_req_val_i(mem_req_val_i),
        .mem_req_rdy_o(mem_req_rdy_o),
        .mem_req_is_write_i(mem_req_is_write_i),
        .mem_req_is_cas_i(mem_req_is_cas_i),
        .mem_req_addr_i(mem_req_addr_i),
        .mem_req_data_i(mem_req_data_i),
        .mem_rsp_val_o(mem_rsp_val_o),
        .mem_rsp_rdy_i(mem_rsp_rdy_i),
        .mem_rsp_data_o(mem_rsp_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Issues one request with mem_rsp_rdy_i high; returns response data and accept-to-valid latency.
    task automatic do_req(input logic w, input logic c, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata, output int lat);
        check("req_rdy_before_accept", {31'b0, mem_req_rdy_o}, 32'd1);
        mem_req_val_i      = 1'b1;
        mem_req_is_write_i = w;
        mem_req_is_cas_i   = c;
        mem_req_addr_i     = a;
        mem_req_data_i     = d;
        step();
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        mem_req_is_cas_i   = 1'b0;
        lat = 0;
        while (!mem_rsp_val_o && lat < 50) begin
            step();
            lat++;
        end
        rdata = mem_rsp_data_o;
        step();
        check("req_rdy_after_handshake", {31'b0, mem_req_rdy_o}, 32'd1);
    endtask

    logic [31:0] rd;
    int          lat;
    int          seen_val;

    initial begin
        rst_i              = 1'b1;
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        mem_req_is_cas_i   = 1'b0;
        mem_req_addr_i     = '0;
        mem_req_data_i     = '0;
        mem_rsp_rdy_i      = 1'b1;
        step();
        check("reset_req_rdy", {31'b0, mem_req_rdy_o}, 32'd1);
        check("reset_rsp_val", {31'b0, mem_rsp_val_o}, 32'd0);
        check("reset_rsp_data", mem_rsp_data_o, 32'd0);
        step();
        rst_i = 1'b0;
        step();

        // Read of the lock word after reset
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
        check("read0_data", rd, 32'hFFFF_FFFF);
        check("read0_latency", lat, 32'd3);

        do_req(1'b1, 1'b0, 32'h10, 32'hABCD, rd, lat);
        check("write10_rsp", rd, 32'd0);
        check("write10_latency", lat, 32'd3);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat);
        check("read10_data", rd, 32'hABCD);
        do_req(1'b0, 1'b0, 32'h12, 32'h0, rd, lat);
        check("read12_data", rd, 32'hABCD);

        // CAS sequence on the lock word
        do_req(1'b0, 1'b1, 32'h0, 32'h0, rd, lat);
        check("cas1_rsp", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
        check("cas1_word", rd, 32'd0);
        do_req(1'b1, 1'b1, 32'h0, 32'h5, rd, lat);
        check("cas2_rsp", rd, 32'd1);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
        check("cas2_word", rd, 32'd0);
        do_req(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, rd, lat);
        check("unlock_rsp", rd, 32'd0);
        do_req(1'b0, 1'b1, 32'h0, 32'h7, rd, lat);
        check("cas3_rsp", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
        check("cas3_word", rd, 32'h7);

        // Backpressure: response held for 10 cycles while new requests are ignored
        mem_rsp_rdy_i  = 1'b0;
        mem_req_val_i  = 1'b1;
        mem_req_addr_i = 32'h10;
        step();
        mem_req_is_write_i = 1'b1;
        mem_req_addr_i     = 32'h10;
        mem_req_data_i     = 32'h1234;
        check("wait_req_rdy_low", {31'b0, mem_req_rdy_o}, 32'd0);
        check("wait_rsp_data_zero", mem_rsp_data_o, 32'd0);
        lat = 0;
        while (!mem_rsp_val_o && lat < 50) begin
            step();
            lat++;
        end
        check("stall_latency", lat, 32'd3);
        for (int i = 0; i < 10; i++) begin
            check("stall_rsp_val", {31'b0, mem_rsp_val_o}, 32'd1);
            check("stall_rsp_data", mem_rsp_data_o, 32'hABCD);
            check("stall_req_rdy", {31'b0, mem_req_rdy_o}, 32'd0);
            step();
        end
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        mem_rsp_rdy_i      = 1'b1;
        #1;
        check("handshake_req_rdy_low", {31'b0, mem_req_rdy_o}, 32'd0);
        step();
        check("post_hs_req_rdy", {31'b0, mem_req_rdy_o}, 32'd1);
        check("post_hs_rsp_val", {31'b0, mem_rsp_val_o}, 32'd0);
        check("post_hs_rsp_data", mem_rsp_data_o, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat);
        check("ignored_write_10", rd, 32'hABCD);

        // Address wrap: 4*DEPTH+8 aliases word 2
        do_req(1'b1, 1'b0, 32'd264, 32'h55, rd, lat);
        check("wrap_write_rsp", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h8, 32'h0, rd, lat);
        check("wrap_read8", rd, 32'h55);

        // Reset during WAIT aborts a pending write
        mem_req_val_i      = 1'b1;
        mem_req_is_write_i = 1'b1;
        mem_req_addr_i     = 32'h20;
        mem_req_data_i     = 32'h99;
        step();
        mem_req_val_i      = 1'b0;
        mem_req_is_write_i = 1'b0;
        check("abort_in_wait_rdy", {31'b0, mem_req_rdy_o}, 32'd0);
        rst_i = 1'b1;
        #1;
        check("abort_rst_rdy", {31'b0, mem_req_rdy_o}, 32'd1);
        check("abort_rst_val", {31'b0, mem_rsp_val_o}, 32'd0);
        step();
        rst_i = 1'b0;
        seen_val = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (mem_rsp_val_o) seen_val++;
        end
        check("abort_no_response", seen_val, 32'd0);
        do_req(1'b0, 1'b0, 32'h20, 32'h0, rd, lat);
        check("abort_read20", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h10, 32'h0, rd, lat);
        check("abort_read10_cleared", rd, 32'd0);
        do_req(1'b0, 1'b0, 32'h0, 32'h0, rd, lat);
        check("abort_lock_word", rd, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
